// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin write-back arbiter with a register scoreboard.
// Requesters (0 = ALU, 1 = FPU, 2 = LSU) compete for one register-file write port.
// The granted address and data are staged in ard/drd for one cycle.
// A per-register busy bit is set by issue and cleared by write-back.
// Optional macro WB_FORWARD_EN clears busy bits at the transfer edge.
// It also exposes forwarding ports (fwd_hit*, fwd_data*) from the staged write.
// With the macro undefined, busy bits clear one edge later, from ard.
module reg_wb_arbiter #(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned LEN_REG_ADDR = 6,
  parameter int unsigned LEN_WORD     = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*LEN_REG_ADDR-1:0] req_addr,
  input  logic [N_REQ*LEN_WORD-1:0]     req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [LEN_REG_ADDR-1:0]       ard,
  output logic [LEN_WORD-1:0]           drd,
  input  logic                          issue_valid,
  input  logic [LEN_REG_ADDR-1:0]       issue_addr,
  input  logic [LEN_REG_ADDR-1:0]       chk_addr1,
  input  logic [LEN_REG_ADDR-1:0]       chk_addr2,
  output logic                          busy1,
  output logic                          busy2,
  output logic                          err_waw
`ifdef WB_FORWARD_EN
  ,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic [LEN_WORD-1:0]           fwd_data1,
  output logic [LEN_WORD-1:0]           fwd_data2
`endif
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned N_REGS = 2 ** LEN_REG_ADDR;

  logic [IDX_W-1:0]        last_grant;
  logic [IDX_W-1:0]        gnt_idx;
  logic [N_REQ-1:0]        grant;
  logic                    xfer;
  int unsigned             cand;
  logic [LEN_REG_ADDR-1:0] sel_addr;
  logic [LEN_WORD-1:0]     sel_data;

  logic [N_REGS-1:0]       busy_q;
  logic [N_REGS-1:0]       busy_nxt;
  logic [LEN_REG_ADDR-1:0] clr_addr;
  logic                    clr_en;
  logic                    set_en;
  logic                    err_nxt;

  // Round-robin search from last_grant+1; nothing is granted while in reset
  always_comb begin : p_arb
    grant    = '0;
    gnt_idx  = last_grant;
    xfer     = 1'b0;
    cand     = 0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_grant) + k) % N_REQ;
      if (!xfer && req_valid[IDX_W'(cand)]) begin
        xfer                 = 1'b1;
        grant[IDX_W'(cand)]  = 1'b1;
        gnt_idx              = IDX_W'(cand);
        sel_addr             = req_addr[cand*LEN_REG_ADDR +: LEN_REG_ADDR];
        sel_data             = req_data[cand*LEN_WORD +: LEN_WORD];
      end
    end
    if (!rstn) begin
      grant = '0;
      xfer  = 1'b0;
    end
  end

  assign req_ready = grant;

  // Scoreboard next state: clear from write-back, then set from issue (set wins)
  always_comb begin : p_sb
    busy_nxt = busy_q;
`ifdef WB_FORWARD_EN
    clr_addr = xfer ? sel_addr : '0;
`else
    clr_addr = ard;
`endif
    clr_en   = (clr_addr != '0);
    set_en   = issue_valid && (issue_addr != '0);
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    err_nxt  = set_en && busy_q[issue_addr] && !(clr_en && (clr_addr == issue_addr));
  end

  // Staged write port, round-robin pointer, scoreboard and WAW flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant <= IDX_W'(N_REQ - 1);
      ard        <= '0;
      drd        <= '0;
      busy_q     <= '0;
      err_waw    <= 1'b0;
    end else begin
      if (xfer) begin
        last_grant <= gnt_idx;
        ard        <= sel_addr;
        drd        <= sel_data;
      end else begin
        ard        <= '0;
      end
      busy_q  <= busy_nxt;
      err_waw <= err_nxt;
    end
  end

  assign busy1 = (chk_addr1 != '0) && busy_q[chk_addr1];
  assign busy2 = (chk_addr2 != '0) && busy_q[chk_addr2];

`ifdef WB_FORWARD_EN
  assign fwd_hit1  = (ard != '0) && (ard == chk_addr1);
  assign fwd_hit2  = (ard != '0) && (ard == chk_addr2);
  assign fwd_data1 = drd;
  assign fwd_data2 = drd;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: arbitration order, staging, scoreboard, reset.
module tb_reg_wb_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic             clk;
  logic             rstn;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [AW-1:0]    ard;
  logic [DW-1:0]    drd;
  logic             issue_valid;
  logic [AW-1:0]    issue_addr;
  logic [AW-1:0]    chk_addr1;
  logic [AW-1:0]    chk_addr2;
  logic             busy1;
  logic             busy2;
  logic             err_waw;
`ifdef WB_FORWARD_EN
  logic             fwd_hit1;
  logic             fwd_hit2;
  logic [DW-1:0]    fwd_data1;
  logic [DW-1:0]    fwd_data2;
`endif

  int vectors;
  int miscompares;

  reg_wb_arbiter #(.N_REQ(NR), .LEN_REG_ADDR(AW), .LEN_WORD(DW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .ard(ard), .drd(drd),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .busy1(busy1), .busy2(busy2), .err_waw(err_waw)
`ifdef WB_FORWARD_EN
    , .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  int          exp_g [6];
  logic [2:0]  exp_rdy;

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_g       = '{1, 2, 0, 1, 2, 0};
    rstn        = 1'b0;
    req_valid   = 3'b111;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    chk_addr1   = 6'd5;
    chk_addr2   = '0;

    // Reset state
    tick();
    tick();
    check("rst_ard", 64'(ard), 64'd0);
    check("rst_drd", 64'(drd), 64'd0);
    check("rst_err", 64'(err_waw), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);

    // Issue r5, then ALU writes it back
    rstn      = 1'b1;
    req_valid = '0;
    tick();
    issue_valid = 1'b1;
    issue_addr  = 6'd5;
    tick();
    issue_valid = 1'b0;
    check("r5_busy_set", 64'(busy1), 64'd1);
    req_valid = 3'b001;
    set_req(0, 6'd5, 32'h12345678);
    #1;
    check("r5_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    check("r5_ard", 64'(ard), 64'd5);
    check("r5_drd", 64'(drd), 64'h12345678);
`ifdef WB_FORWARD_EN
    check("r5_busy_at_e", 64'(busy1), 64'd0);
    check("r5_fwd_hit", 64'(fwd_hit1), 64'd1);
    check("r5_fwd_data", 64'(fwd_data1), 64'h12345678);
`else
    check("r5_busy_at_e", 64'(busy1), 64'd1);
`endif
    tick();
    check("r5_ard_idle", 64'(ard), 64'd0);
    check("r5_drd_hold", 64'(drd), 64'h12345678);
    check("r5_busy_e1", 64'(busy1), 64'd0);

    // Continuous contention: last grant was 0, so order is 1,2,0,1,2,0
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) set_req(i, AW'(i + 1), 32'h000000A0 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_rdy = 3'(1 << exp_g[i]);
      check("rr_ready", 64'(req_ready), 64'(exp_rdy));
      tick();
      check("rr_ard", 64'(ard), 64'(exp_g[i] + 1));
      check("rr_drd", 64'(drd), 64'(32'h000000A0 + 32'(exp_g[i])));
    end
    req_valid = '0;
    tick();
    check("rr_idle_ard", 64'(ard), 64'd0);

    // Double issue of r9 without write-back
    chk_addr2   = 6'd9;
    issue_valid = 1'b1;
    issue_addr  = 6'd9;
    tick();
    check("waw_first_err", 64'(err_waw), 64'd0);
    check("waw_busy2", 64'(busy2), 64'd1);
    tick();
    issue_valid = 1'b0;
    check("waw_err_pulse", 64'(err_waw), 64'd1);
    tick();
    check("waw_err_drop", 64'(err_waw), 64'd0);

    // r7 busy, LSU writes r7 back, re-issue coincides with the clear edge
    chk_addr1   = 6'd7;
    issue_valid = 1'b1;
    issue_addr  = 6'd7;
    tick();
    issue_valid = 1'b0;
    check("r7_busy", 64'(busy1), 64'd1);
    req_valid = 3'b100;
    set_req(2, 6'd7, 32'h00000077);
    #1;
    check("r7_ready", 64'(req_ready), 64'b100);
`ifdef WB_FORWARD_EN
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    req_valid   = '0;
`else
    tick();
    req_valid   = '0;
    check("r7_ard", 64'(ard), 64'd7);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
`endif
    check("r7_set_wins", 64'(busy1), 64'd1);
    check("r7_no_err", 64'(err_waw), 64'd0);
    tick();
    check("r7_still_busy", 64'(busy1), 64'd1);

    // FPU writes r0: accepted but discarded
    chk_addr1 = 6'd0;
    req_valid = 3'b010;
    set_req(1, 6'd0, 32'hFFFFFFFF);
    #1;
    check("r0_ready", 64'(req_ready), 64'b010);
    check("r0_busy_pre", 64'(busy1), 64'd0);
    tick();
    req_valid = '0;
    check("r0_ard", 64'(ard), 64'd0);
    check("r0_drd", 64'(drd), 64'hFFFFFFFF);
    check("r0_busy", 64'(busy1), 64'd0);

    // Reset right after a grant drops the staged write and busy bits
    chk_addr1 = 6'd7;
    req_valid = 3'b100;
    set_req(2, 6'd10, 32'h000000AA);
    #1;
    check("pre_rst_ready", 64'(req_ready), 64'b100);
    tick();
    check("pre_rst_ard", 64'(ard), 64'd10);
    rstn      = 1'b0;
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) set_req(i, AW'(i + 1), 32'h000000B0 + 32'(i));
    #1;
    check("in_rst_ready", 64'(req_ready), 64'd0);
    tick();
    check("post_rst_ard", 64'(ard), 64'd0);
    check("post_rst_drd", 64'(drd), 64'd0);
    check("post_rst_busy7", 64'(busy1), 64'd0);
    check("post_rst_busy9", 64'(busy2), 64'd0);
    rstn = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'b001);
    tick();
    check("post_rst_grant_ard", 64'(ard), 64'd1);
    check("post_rst_grant_drd", 64'(drd), 64'h000000B0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
